ahb_addr_filter: RTL

AHB_ADDR_FILTER -- requirements
Module: ahb_addr_filter

---
 rtl/ahb_addr_filter_pkg.sv | 29 ++
 rtl/ahb_addr_filter_if.sv | 22 ++
 rtl/ahb_addr_filter_region_match.sv | 11 +
 rtl/ahb_addr_filter.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/ahb_addr_filter_pkg.sv
// Shared types and default address map for the AHB address filter.
// The default map deliberately overlaps regions 0 and 3 (small window inside a large one).
package ahb_filter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ERR1 = 2'd1,
    ST_ERR2 = 2'd2
  } filt_state_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;

  localparam int DEFAULT_NUM_SLAVES = 6;

  // Entry 0 is the rightmost element of each concatenation.
  localparam logic [5:0][31:0] DEFAULT_BASE = {
    32'h5000_0000, 32'h4000_0000, 32'h0000_0000,
    32'h2000_0000, 32'h1000_0000, 32'h0000_0000
  };

  localparam logic [5:0][31:0] DEFAULT_MASK = {
    32'hF000_0000, 32'hFF00_0000, 32'hF000_0000,
    32'hFFFF_F000, 32'hFFF0_0000, 32'hFFFF_0000
  };

endpackage

// File: rtl/ahb_addr_filter_if.sv
// AHB address-phase signals seen by the filter plus its default-slave response.
// Signal suffixes are relative to the filter (slave side).
interface ahb_addr_filter_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  hsel_i;
  logic [ADDR_WIDTH-1:0] haddr_i;
  logic [1:0]            htrans_i;
  logic                  hready_i;
  logic                  hreadyout_o;
  logic                  hresp_o;

  modport master (
    output hsel_i, haddr_i, htrans_i, hready_i,
    input  hreadyout_o, hresp_o
  );

  modport slave (
    input  hsel_i, haddr_i, htrans_i, hready_i,
    output hreadyout_o, hresp_o
  );
endinterface

// File: rtl/ahb_addr_filter_region_match.sv
// Single-region masked address compare; mask bit 1 means the bit takes part.
module addr_region_match #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [ADDR_WIDTH-1:0] base_i,
  input  logic [ADDR_WIDTH-1:0] mask_i,
  output logic                  hit_o
);
  assign hit_o = ((addr_i & mask_i) == (base_i & mask_i));
endmodule

// File: rtl/ahb_addr_filter.sv
// AHB address decoder with default slave: one-hot selects, two-cycle ERROR on unmapped
// transfers, and first-error address capture with a saturating miss counter.
module ahb_addr_filter
  import ahb_filter_pkg::*;
#(
  parameter int NUM_SLAVES = DEFAULT_NUM_SLAVES,
  parameter int ADDR_WIDTH = 32,
  parameter logic [NUM_SLAVES-1:0][ADDR_WIDTH-1:0] BASE_ADDR = DEFAULT_BASE,
  parameter logic [NUM_SLAVES-1:0][ADDR_WIDTH-1:0] MASK_ADDR = DEFAULT_MASK,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ahb_addr_filter_if.slave      bus,
  output logic [NUM_SLAVES-1:0] sel_addr_o,
  output logic [NUM_SLAVES-1:0] sel_data_o,
  output logic                  err_valid_o,
  output logic [ADDR_WIDTH-1:0] err_addr_o,
  output logic [CNT_WIDTH-1:0]  err_cnt_o,
  input  logic                  err_clr_i
);

  logic [NUM_SLAVES-1:0] hit;
  logic [NUM_SLAVES-1:0] sel_addr;
  logic                  found;
  logic                  addr_req;
  logic                  miss;

  filt_state_e           state_q;
  logic                  hreadyout_q;
  logic                  hresp_q;
  logic [NUM_SLAVES-1:0] sel_data_q;

  logic                  err_valid_q, err_valid_d;
  logic [ADDR_WIDTH-1:0] err_addr_q,  err_addr_d;
  logic [CNT_WIDTH-1:0]  err_cnt_q,   err_cnt_d;

  for (genvar i = 0; i < NUM_SLAVES; i++) begin : g_region
    addr_region_match #(.ADDR_WIDTH(ADDR_WIDTH)) u_match (
      .addr_i (bus.haddr_i),
      .base_i (BASE_ADDR[i]),
      .mask_i (MASK_ADDR[i]),
      .hit_o  (hit[i])
    );
  end

  assign addr_req = bus.hsel_i &&
                    ((bus.htrans_i == HTRANS_NONSEQ) || (bus.htrans_i == HTRANS_SEQ));
  assign miss     = addr_req && bus.hready_i && !(|hit);

  // Lowest-index region wins when regions overlap.
  always_comb begin
    sel_addr = '0;
    found    = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (addr_req && hit[i] && !found) begin
        sel_addr[i] = 1'b1;
        found       = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (miss) begin
          state_q     <= ST_ERR1;
          hreadyout_q <= 1'b0;
          hresp_q     <= 1'b1;
        end
        ST_ERR1: begin
          state_q     <= ST_ERR2;
          hreadyout_q <= 1'b1;
          hresp_q     <= 1'b1;
        end
        ST_ERR2: if (miss) begin
          state_q     <= ST_ERR1;
          hreadyout_q <= 1'b0;
          hresp_q     <= 1'b1;
        end else begin
          state_q     <= ST_IDLE;
          hreadyout_q <= 1'b1;
          hresp_q     <= 1'b0;
        end
        default: begin
          state_q     <= ST_IDLE;
          hreadyout_q <= 1'b1;
          hresp_q     <= 1'b0;
        end
      endcase
    end
  end

  // A miss in the clear cycle restarts capture rather than being lost.
  always_comb begin
    err_valid_d = err_valid_q;
    err_addr_d  = err_addr_q;
    err_cnt_d   = err_cnt_q;
    if (err_clr_i) begin
      err_valid_d = 1'b0;
      err_addr_d  = '0;
      err_cnt_d   = '0;
    end
    if (miss) begin
      if (err_clr_i) begin
        err_cnt_d = CNT_WIDTH'(1);
      end else if (!(&err_cnt_q)) begin
        err_cnt_d = err_cnt_q + CNT_WIDTH'(1);
      end
      if (!err_valid_q || err_clr_i) begin
        err_valid_d = 1'b1;
        err_addr_d  = bus.haddr_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_data_q  <= '0;
      err_valid_q <= 1'b0;
      err_addr_q  <= '0;
      err_cnt_q   <= '0;
    end else begin
      if (bus.hready_i) sel_data_q <= sel_addr;
      err_valid_q <= err_valid_d;
      err_addr_q  <= err_addr_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign sel_addr_o      = sel_addr;
  assign sel_data_o      = sel_data_q;
  assign bus.hreadyout_o = hreadyout_q;
  assign bus.hresp_o     = hresp_q;
  assign err_valid_o     = err_valid_q;
  assign err_addr_o      = err_addr_q;
  assign err_cnt_o       = err_cnt_q;

endmodule
